ysyx_24080006_axi_rd_arb: RTL

YSYX_24080006_AXI_RD_ARB -- requirements
Module: ysyx_24080006_axi_rd_arb

---
 rtl/ysyx_24080006_axi_rd_arb.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_rd_arb
//
// Purpose:
//   Two-requester AXI read-channel arbiter (IFU and LSU) in front of a single
//   shared slave. Only one transaction is outstanding at a time. The FSM
//   walks IDLE -> ADDR -> DATA -> IDLE:
//     IDLE : arbitrate and latch a grant. No AR is presented to the slave
//            in this cycle.
//     ADDR : pass the granted requester's AR channel straight through until
//            the AR handshake completes.
//     DATA : pass the R channel back to the granted requester beat by beat
//            until the beat that carries rlast is accepted.
//   The requester that does not hold the grant sees all-zero outputs. In
//   IDLE every output is zero.
//
// Configuration macros:
//   ARB_RR_EN - when defined, simultaneous requests are resolved round-robin
//               using a 1-bit last-grant pointer. When undefined, LSU has
//               fixed priority over IFU.
//   SIM_MODE  - when defined, enables a simulation assertion that flags a
//               granted arvalid dropping before its AR handshake completes.
//
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   ifu_ar*/lsu_ar*       : requester AR channels (valid, addr, id, len,
//                           size, burst in; arready out)
//   ifu_r*/lsu_r*         : requester R channels (valid, data, resp, last,
//                           id out; rready in)
//   m_ar*                 : AR channel to the shared slave
//   m_r*                  : R channel from the shared slave
// ---------------------------------------------------------------------------
module ysyx_24080006_axi_rd_arb (
    input  logic        clock,
    input  logic        reset,

    // IFU requester
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,

    // LSU requester
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,

    // Shared slave
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_t state_reg, state_next;
    logic   grant_reg, grant_next;
    logic   pick;

    // Granted requester's AR channel and rready, selected by the held grant.
    logic        sel_arvalid;
    logic [31:0] sel_araddr;
    logic [3:0]  sel_arid;
    logic [7:0]  sel_arlen;
    logic [2:0]  sel_arsize;
    logic [1:0]  sel_arburst;
    logic        sel_rready;

    always_comb begin
        sel_arvalid = (grant_reg == GNT_LSU) ? lsu_arvalid : ifu_arvalid;
        sel_araddr  = (grant_reg == GNT_LSU) ? lsu_araddr  : ifu_araddr;
        sel_arid    = (grant_reg == GNT_LSU) ? lsu_arid    : ifu_arid;
        sel_arlen   = (grant_reg == GNT_LSU) ? lsu_arlen   : ifu_arlen;
        sel_arsize  = (grant_reg == GNT_LSU) ? lsu_arsize  : ifu_arsize;
        sel_arburst = (grant_reg == GNT_LSU) ? lsu_arburst : ifu_arburst;
        sel_rready  = (grant_reg == GNT_LSU) ? lsu_rready  : ifu_rready;
    end

    // -----------------------------------------------------------------------
    // Arbitration decision (only consumed in IDLE)
    // -----------------------------------------------------------------------
`ifdef ARB_RR_EN
    // Last requester granted; on a tie the other requester wins.
    logic last_grant_reg;

    always_comb begin
        pick = GNT_IFU;
        if (ifu_arvalid && lsu_arvalid) begin
            pick = ~last_grant_reg;
        end else if (lsu_arvalid) begin
            pick = GNT_LSU;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= GNT_IFU;
        end else if (state_reg == ST_IDLE && (ifu_arvalid || lsu_arvalid)) begin
            last_grant_reg <= pick;
        end
    end
`else
    // Fixed priority: LSU over IFU.
    always_comb begin
        pick = lsu_arvalid ? GNT_LSU : GNT_IFU;
    end
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= GNT_IFU;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state; the grant can only change while leaving IDLE
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    state_next = ST_ADDR;
                    grant_next = pick;
                end
            end
            ST_ADDR: begin
                if (sel_arvalid && m_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rvalid && sel_rready && m_rlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output routing. Everything defaults to zero, so IDLE and the
    // non-granted requester are silent without extra terms.
    // -----------------------------------------------------------------------
    always_comb begin
        m_arvalid   = 1'b0;
        m_araddr    = 32'd0;
        m_arid      = 4'd0;
        m_arlen     = 8'd0;
        m_arsize    = 3'd0;
        m_arburst   = 2'd0;
        m_rready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'd0;
        ifu_rlast   = 1'b0;
        ifu_rid     = 4'd0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'd0;
        lsu_rlast   = 1'b0;
        lsu_rid     = 4'd0;
        case (state_reg)
            ST_ADDR: begin
                m_arvalid = sel_arvalid;
                m_araddr  = sel_araddr;
                m_arid    = sel_arid;
                m_arlen   = sel_arlen;
                m_arsize  = sel_arsize;
                m_arburst = sel_arburst;
                if (grant_reg == GNT_LSU) begin
                    lsu_arready = m_arready;
                end else begin
                    ifu_arready = m_arready;
                end
            end
            ST_DATA: begin
                m_rready = sel_rready;
                if (grant_reg == GNT_LSU) begin
                    lsu_rvalid = m_rvalid;
                    lsu_rdata  = m_rdata;
                    lsu_rresp  = m_rresp;
                    lsu_rlast  = m_rlast;
                    lsu_rid    = m_rid;
                end else begin
                    ifu_rvalid = m_rvalid;
                    ifu_rdata  = m_rdata;
                    ifu_rresp  = m_rresp;
                    ifu_rlast  = m_rlast;
                    ifu_rid    = m_rid;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef SIM_MODE
    // A granted arvalid must stay high until the slave accepts it. The value
    // is still forwarded as-is; this only reports the violation.
    a_arvalid_held: assert property (
        @(posedge clock) disable iff (!reset)
        (state_reg == ST_ADDR) |-> sel_arvalid
    ) else $error("granted arvalid dropped before AR handshake");
`endif

endmodule
